tick_timer_arbiter: RTL and testbench

TICK_TIMER_ARBITER -- requirements
Module: tick_timer_arbiter

---
 rtl/tick_timer_arbiter.sv | 98 +++++++++
 tb/tb_tick_timer_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: several requesters share one tick-driven down-counter.
// The idle arbiter picks a round-robin winner and loads that winner's delay.
// The winner then owns the counter until its delay has elapsed in ticks,
// which ends in a one-cycle done pulse, or until it drops its request, which
// ends the run with no done pulse. Only one requester is served at a time.
module tick_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] delay,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  cnt;
    logic [IW-1:0] lp;
    logic [IW-1:0] owner;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [W-1:0]  win_delay;
    int            cand;

    // Round-robin scan: first asserted request after the last owner, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(lp) + k) % NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
        win_delay = delay[win_idx*W +: W];
    end

    // Arbitration, countdown, completion and abort sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            cnt   <= '0;
            lp    <= IW'(NREQ - 1);
            owner <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant <= NREQ'(1) << win_idx;
                        owner <= win_idx;
                        cnt   <= win_delay;
                        state <= (win_delay == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        grant <= '0;
                        lp    <= owner;
                        state <= IDLE;
                    end else if (tick) begin
                        cnt <= cnt - W'(1);
                        if (cnt == W'(1)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    done  <= grant;
                    grant <= '0;
                    lp    <= owner;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Bench for tick_timer_arbiter: directed scenarios followed by a randomized
// phase, all checked every cycle against a transaction-level reference model.
module tb_tick_timer_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk;
    logic              rst;
    logic              tick;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] delay;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;

    int testCount;
    int failCount;

    // Reference model: who is being served, how many ticks remain, and
    // whether the completion pulse is due on the next edge.
    int              mOwner;
    int              mRemain;
    bit              mFinishDue;
    int              mLast;
    logic [NREQ-1:0] mGrant;
    logic [NREQ-1:0] mDone;

    logic [NREQ-1:0] doneLog[$];

    tick_timer_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .req  (req),
        .delay(delay),
        .grant(grant),
        .done (done),
        .busy (busy)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelEdge();
        int w;
        mDone = '0;
        if (rst) begin
            mOwner = -1; mFinishDue = 0; mGrant = '0; mLast = NREQ - 1; mRemain = 0;
        end else if (mFinishDue) begin
            mDone = NREQ'(1) << mOwner;
            mLast = mOwner; mOwner = -1; mFinishDue = 0; mGrant = '0;
        end else if (mOwner >= 0) begin
            if (!req[mOwner]) begin
                mLast = mOwner; mOwner = -1; mGrant = '0;
            end else if (tick) begin
                mRemain = mRemain - 1;
                if (mRemain == 0) mFinishDue = 1;
            end
        end else if (req != '0) begin
            w = -1;
            for (int k = 1; k <= NREQ && w < 0; k++) begin
                if (req[(mLast + k) % NREQ]) w = (mLast + k) % NREQ;
            end
            mOwner = w;
            mRemain = int'(delay[w*W +: W]);
            mGrant = NREQ'(1) << w;
            if (mRemain == 0) mFinishDue = 1;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("grant", 32'(grant), 32'(mGrant));
        checkValue("done", 32'(done), 32'(mDone));
        checkValue("busy", 32'(busy), 32'(mGrant != '0));
        if (done != '0) doneLog.push_back(done);
    endtask

    task automatic stepClock();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq, input logic t);
        rst = r; req = rq; tick = t;
    endtask

    task automatic setDelay(input int idx, input int value);
        delay[idx*W +: W] = W'(value);
    endtask

    int dc;
    int tickCycle;

    initial begin
        testCount = 0; failCount = 0;
        mOwner = -1; mRemain = 0; mFinishDue = 0; mLast = NREQ - 1;
        mGrant = '0; mDone = '0;
        delay = '0;
        applyStimulus(1'b1, '0, 1'b0);
        #1;
        stepClock();
        stepClock();
        checkValue("reset_grant", 32'(grant), 32'h0);
        checkValue("reset_busy", 32'(busy), 32'h0);
        applyStimulus(1'b0, '0, 1'b0);
        stepClock();

        // Single requester, delay 3, tick every 4th cycle
        setDelay(0, 3);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        stepClock();
        checkValue("single_grant", 32'(grant), 32'h1);
        doneLog.delete();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, 4'b0001, (i % 4) == 3);
            stepClock();
        end
        checkValue("single_done_count", 32'(doneLog.size()), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        stepClock();
        checkValue("single_grant_cleared", 32'(grant), 32'h0);

        // All four requesting with delay 1 and a constant tick: rotation order
        applyStimulus(1'b1, '0, 1'b0);
        stepClock();
        for (int i = 0; i < NREQ; i++) setDelay(i, 1);
        doneLog.delete();
        dc = 0;
        while (doneLog.size() < 5 && dc < 60) begin
            applyStimulus(1'b0, 4'b1111, 1'b1);
            stepClock();
            dc++;
        end
        checkValue("rr_done_total", 32'(doneLog.size()), 32'd5);
        if (doneLog.size() >= 5) begin
            checkValue("rr_done0", 32'(doneLog[0]), 32'h1);
            checkValue("rr_done1", 32'(doneLog[1]), 32'h2);
            checkValue("rr_done2", 32'(doneLog[2]), 32'h4);
            checkValue("rr_done3", 32'(doneLog[3]), 32'h8);
            checkValue("rr_done4", 32'(doneLog[4]), 32'h1);
        end
        applyStimulus(1'b1, '0, 1'b0);
        stepClock();

        // Zero delay completes without ticks
        setDelay(2, 0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        stepClock();
        checkValue("zero_grant", 32'(grant), 32'h4);
        stepClock();
        checkValue("zero_done", 32'(done), 32'h4);
        checkValue("zero_grant_cleared", 32'(grant), 32'h0);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        stepClock();

        // Abort after two ticks, then round robin continues past requester 1
        setDelay(1, 5);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        stepClock();
        checkValue("abort_grant", 32'(grant), 32'h2);
        applyStimulus(1'b0, 4'b0010, 1'b1); stepClock();
        applyStimulus(1'b0, 4'b0010, 1'b0); stepClock();
        applyStimulus(1'b0, 4'b0010, 1'b1); stepClock();
        applyStimulus(1'b0, 4'b0000, 1'b1); stepClock();
        checkValue("abort_grant_cleared", 32'(grant), 32'h0);
        checkValue("abort_no_done", 32'(done), 32'h0);
        setDelay(0, 2);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        stepClock();
        checkValue("after_abort_grant", 32'(grant), 32'h1);

        // Reset in the middle of a long run cancels it silently
        applyStimulus(1'b1, '0, 1'b0); stepClock();
        setDelay(0, 10);
        applyStimulus(1'b0, 4'b0001, 1'b0); stepClock();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b0001, 1'b1); stepClock();
        end
        applyStimulus(1'b1, 4'b0001, 1'b0); stepClock();
        checkValue("rst_mid_grant", 32'(grant), 32'h0);
        checkValue("rst_mid_busy", 32'(busy), 32'h0);
        checkValue("rst_mid_done", 32'(done), 32'h0);
        setDelay(3, 2);
        applyStimulus(1'b0, 4'b1000, 1'b0); stepClock();
        checkValue("after_rst_grant", 32'(grant), 32'h8);
        applyStimulus(1'b1, '0, 1'b0); stepClock();

        // A tick in the selection cycle is not counted
        setDelay(0, 1);
        applyStimulus(1'b0, 4'b0001, 1'b1); stepClock();
        applyStimulus(1'b0, 4'b0001, 1'b0); stepClock();
        checkValue("sel_tick_no_done_a", 32'(done), 32'h0);
        stepClock();
        applyStimulus(1'b0, 4'b0001, 1'b1); stepClock();
        checkValue("sel_tick_no_done_b", 32'(done), 32'h0);
        applyStimulus(1'b0, 4'b0000, 1'b0); stepClock();
        checkValue("sel_tick_done", 32'(done), 32'h1);

        // Randomized traffic: requests, delays and ticks vary, with occasional reset
        tickCycle = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) setDelay(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 6)));
            tick = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            stepClock();
            tickCycle++;
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
